// File: rtl/bola_fisica.sv
// bola_fisica: Breakout ball motion and wall/bar collision engine, stepped once per frame tick.
module bola_fisica #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BALL     = 8,
    parameter int BAR_W    = 64,
    parameter int BAR_Y    = 440,
    parameter int TICK_DIV = 416667,
    parameter int VEL      = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       launch,
    input  logic [9:0] bar_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit_bar,
    output logic       start,
    output logic       game_over
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [10:0] L_VEL    = 11'(VEL);
    localparam logic [10:0] L_BALL   = 11'(BALL);
    localparam logic [10:0] L_BAR_W  = 11'(BAR_W);
    localparam logic [10:0] L_BAR_Y  = 11'(BAR_Y);
    localparam logic [10:0] L_X_MAX  = 11'(H_RES - BALL);
    localparam logic [10:0] L_Y_MAX  = 11'(V_RES - BALL);
    localparam logic [10:0] L_Y_REST = 11'(BAR_Y - BALL);
    localparam logic [10:0] L_CENTER = 11'((BAR_W - BALL) / 2);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [9:0]      r_x, r_y;
    logic            r_right, r_up, r_launch_prev, r_hit, r_start, r_over;

    logic            w_tick, w_rise, w_bar_hit, w_lost, w_nright, w_nup;
    logic [10:0]     w_x, w_y, w_bx, w_ydown;
    logic [9:0]      w_nx, w_ny, w_home;

    assign w_tick = r_cnt == CW'(TICK_DIV - 1);
    assign w_rise = launch & ~r_launch_prev;
    assign w_x    = {1'b0, r_x};
    assign w_y    = {1'b0, r_y};
    assign w_bx   = {1'b0, bar_x};
    assign w_home = 10'(w_bx + L_CENTER);

    // Axes are resolved independently so a corner reflects both in one tick.
    assign w_nx     = 10'(r_right ? ((w_x + L_VEL > L_X_MAX) ? L_X_MAX : w_x + L_VEL)
                                  : ((w_x < L_VEL) ? 11'd0 : w_x - L_VEL));
    assign w_nright = r_right ? !(w_x + L_VEL > L_X_MAX) : (w_x < L_VEL);

    assign w_ydown   = w_y + L_VEL;
    assign w_bar_hit = !r_up && (w_y + L_BALL <= L_BAR_Y) && (w_y + L_BALL + L_VEL >= L_BAR_Y)
                       && (w_x + L_BALL > w_bx) && (w_x < w_bx + L_BAR_W);
    assign w_lost    = !r_up && !w_bar_hit && (w_ydown >= L_Y_MAX);
    assign w_ny      = 10'(r_up ? ((w_y < L_VEL) ? 11'd0 : w_y - L_VEL)
                                : w_bar_hit ? L_Y_REST : w_lost ? L_Y_MAX : w_ydown);
    assign w_nup     = r_up ? !(w_y < L_VEL) : w_bar_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_x           <= 10'((H_RES - BALL) / 2);
            r_y           <= 10'(BAR_Y - BALL);
            r_right       <= 1'b1;
            r_up          <= 1'b1;
            r_launch_prev <= 1'b0;
            r_hit         <= 1'b0;
            r_start       <= 1'b0;
            r_over        <= 1'b0;
        end else begin
            r_cnt         <= w_tick ? '0 : r_cnt + CW'(1);
            r_launch_prev <= launch;
            r_start       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_x <= w_home;
                        r_y <= 10'(L_Y_REST);
                    end
                    if (w_rise) begin
                        r_state <= RUN;
                        r_right <= 1'b1;
                        r_up    <= 1'b1;
                        r_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        r_x     <= w_nx;
                        r_right <= w_nright;
                        r_y     <= w_ny;
                        r_up    <= w_nup;
                        r_hit   <= w_bar_hit;
                        if (w_lost) begin
                            r_state <= OVER;
                            r_over  <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    // Leaving OVER only re-arms the game; a fresh press in IDLE starts it.
                    if (w_rise) begin
                        r_state <= IDLE;
                        r_over  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign hit_bar   = r_hit;
    assign start     = r_start;
    assign game_over = r_over;
endmodule

// File: tb/tb_bola_fisica.sv
// tb_bola_fisica: scoreboard bench; expected outputs keyed by cycle, checked by an independent monitor.
module tb_bola_fisica;
    logic       clock = 1'b0;
    logic       reset;
    logic       launch;
    logic [9:0] bar_x;
    logic [9:0] ball_x, ball_y;
    logic       hit_bar, start, game_over;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic       h;
        logic       s;
        logic       g;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;

    bola_fisica #(.TICK_DIV(4), .VEL(2)) dut (
        .clock(clock), .reset(reset), .launch(launch), .bar_x(bar_x),
        .ball_x(ball_x), .ball_y(ball_y), .hit_bar(hit_bar),
        .start(start), .game_over(game_over)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push(input int c, input int x, input int y, input logic h,
                        input logic s, input logic g, input string name);
        exp_t e;
        e.cyc = c; e.x = 10'(x); e.y = 10'(y); e.h = h; e.s = s; e.g = g; e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_neg(input int k);
        while (cyc != k) @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.cyc != cyc || ball_x !== e.x || ball_y !== e.y || hit_bar !== e.h
                || start !== e.s || game_over !== e.g) begin
                n_fail++;
                $display("FAIL %s at cyc %0d: got x=%0d y=%0d hit=%b start=%b over=%b, want cyc %0d x=%0d y=%0d hit=%b start=%b over=%b",
                         e.name, cyc, ball_x, ball_y, hit_bar, start, game_over,
                         e.cyc, e.x, e.y, e.h, e.s, e.g);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; launch = 1'b0; bar_x = 10'd172;
        push(0,    316, 432, 0, 0, 0, "reset");
        push(4,    200, 432, 0, 0, 0, "idle_tick");
        push(5,    200, 432, 0, 1, 0, "start_pulse");
        push(6,    200, 432, 0, 0, 0, "start_end");
        push(8,    202, 430, 0, 0, 0, "first_run_tick");
        push(868,  632,   0, 0, 0, 0, "corner_reach");
        push(872,  632,   0, 0, 0, 0, "corner_reflect");
        push(876,  630,   2, 0, 0, 0, "corner_after");
        push(1732, 202, 430, 0, 0, 0, "pre_bar");
        push(1736, 200, 432, 1, 0, 0, "bar_hit");
        push(1737, 200, 432, 1, 0, 0, "hit_hold1");
        push(1738, 200, 432, 1, 0, 0, "hit_hold2");
        push(1739, 200, 432, 1, 0, 0, "hit_hold3");
        push(1740, 198, 430, 0, 0, 0, "hit_clear");
        push(2136,   0, 232, 0, 0, 0, "left_reach");
        push(2140,   0, 230, 0, 0, 0, "left_reflect");
        push(2144,   2, 228, 0, 0, 0, "left_after");
        push(2600, 230,   0, 0, 0, 0, "top_reach");
        push(2604, 232,   0, 0, 0, 0, "top_reflect");
        push(2608, 234,   2, 0, 0, 0, "top_after");
        push(3404, 632, 400, 0, 0, 0, "right_reach");
        push(3408, 632, 402, 0, 0, 0, "right_reflect");
        push(3412, 630, 404, 0, 0, 0, "right_after");
        push(3468, 602, 432, 0, 0, 0, "bar_miss1");
        push(3472, 600, 434, 0, 0, 0, "bar_miss2");
        push(3544, 564, 470, 0, 0, 0, "pre_loss");
        push(3548, 562, 472, 0, 0, 1, "loss");
        push(3560, 562, 472, 0, 0, 1, "frozen");
        push(3561, 562, 472, 0, 0, 0, "over_to_idle");
        push(3562, 562, 472, 0, 0, 0, "no_start_from_over");
        push(3564, 328, 432, 0, 0, 0, "idle_recenter");
        push(3580, 328, 432, 0, 0, 0, "held_stays_idle");
        push(3585, 328, 432, 0, 1, 0, "restart_pulse");
        push(3586, 328, 432, 0, 0, 0, "restart_end");
        push(3588, 330, 430, 0, 0, 0, "restart_run");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        wait_neg(4);    launch = 1'b1;
        wait_neg(100);  launch = 1'b0;
        wait_neg(2000); bar_x = 10'd300;
        wait_neg(3560); launch = 1'b1;
        wait_neg(3580); launch = 1'b0;
        wait_neg(3584); launch = 1'b1;
        wait_neg(3589);
        @(posedge clock);
        #1 reset = 1'b0;
        push(0, 316, 432, 0, 0, 0, "mid_run_reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL unconsumed: got %0d pending expectations, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bola_fisica.md
Name: bola_fisica

Overview:
Ball motion and collision engine for the Breakout game. Advances the ball position once per frame tick and reflects it off the left, right and top walls and off the player bar. Drives the bar-hit and new-game strobes consumed by the score display block. Also reports loss of the ball, with position outputs going to the video renderer.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BALL, 8, ball side length in pixels (square ball)
BAR_W, 64, bar width in pixels
BAR_Y, 440, y coordinate of the bar's top edge
TICK_DIV, 416667, clocks per motion tick (60 Hz at 25 MHz); legal minimum is 2
VEL, 2, pixels moved per tick on each axis

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
launch  in  1  player button, level; only its rising edge is used
bar_x  in  10  left edge of the bar in pixels
ball_x  out  10  left edge of the ball
ball_y  out  10  top edge of the ball
hit_bar  out  1  level; high for exactly one tick period after a bar bounce
start  out  1  one-clock pulse when a new game begins
game_over  out  1  high while the ball is lost

Behaviour:
- Reset is asynchronous and active-low: one clock domain (clock), reset port named reset. While reset=0:
  - state=IDLE
  - ball_x=(H_RES-BALL)/2, ball_y=BAR_Y-BALL
  - dx=+1 (moving right), dy=-1 (moving up)
  - tick counter=0, launch_prev=0
  - hit_bar=0, start=0, game_over=0
  - Reset asserted mid-game returns to this state immediately.
- Tick counter:
  - Free-running over 0..TICK_DIV-1 in every state.
  - tick=1 on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- launch_rise = launch & ~launch_prev. launch_prev is registered every cycle.
- State IDLE:
  - On every tick: ball_x = bar_x+(BAR_W-BALL)/2, ball_y = BAR_Y-BALL.
  - On launch_rise: next state RUN; dx=+1, dy=-1; start=1 for that one clock only.
- State RUN, evaluated only on tick. Each axis is evaluated independently, so a corner hit reflects both axes in the same tick.
  - Horizontal, moving left: if ball_x<VEL, then ball_x=0 and dx=+1; else ball_x-=VEL.
  - Horizontal, moving right: if ball_x+VEL>H_RES-BALL, then ball_x=H_RES-BALL and dx=-1; else ball_x+=VEL.
  - Vertical, moving up: if ball_y<VEL, then ball_y=0 and dy=+1; else ball_y-=VEL.
  - Vertical, moving down, bar hit: applies when ball_y+BALL<=BAR_Y, ball_y+BALL+VEL>=BAR_Y, ball_x+BALL>bar_x and ball_x<bar_x+BAR_W. Then ball_y=BAR_Y-BALL, dy=-1, hit_bar=1.
  - Vertical, moving down, otherwise: ball_y+=VEL. If the new ball_y>=V_RES-BALL, then ball_y=V_RES-BALL, next state OVER, game_over=1.
  - A bar hit takes priority over the loss check in the same tick.
- hit_bar is set on the bounce tick and cleared on the next tick, giving exactly TICK_DIV cycles high. Downstream edge detection therefore counts one point per bounce. It is never high outside RUN.
- State OVER:
  - Ball frozen, game_over=1.
  - On launch_rise: state IDLE, game_over=0.
  - start is not pulsed in OVER. A new game needs a second rising edge of launch in IDLE, so a held button cannot chain OVER->IDLE->RUN.
- launch levels in RUN are ignored.
- Arithmetic: all coordinate sums and comparisons use 11-bit unsigned values, so no 10-bit wraparound can occur. bar_x is sampled on each tick, unregistered.

Test Plan:
1. Parameters TICK_DIV=4, VEL=2. Hold reset=0 for 3 clocks -> ball_x=316, ball_y=432, all strobes 0. Release reset, bar_x=100 -> after first tick ball_x=128, ball_y=432.
2. Pulse launch in IDLE -> start high for exactly 1 clock, state RUN. Next tick: ball_x=130, ball_y=430.
3. Ball at x=631 moving right -> after tick x=632 with dx=-1. Ball at y=1 moving up -> y=0 with dy=+1. Both at once at a corner -> both reflect in the same tick.
4. Ball moving down at y=431, bar_x=100, ball_x=120 -> tick sets y=432, dy=-1. hit_bar stays high for exactly 4 clocks, then 0.
5. Same as 4 but bar_x=300 -> no hit. Ball descends to y=472, game_over=1, position frozen, start stays 0.
6. Hold launch high through OVER -> IDLE reached, no RUN and no start. Release and press again -> start pulse. Assert reset mid-RUN -> all outputs return to reset values within the same cycle.
